// File: rtl/dbus_demux3.sv
// ============================================================================
// dbus_demux3 : routes one core load/store at a time to DMEM, MMIO or timer
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dbus_demux3 #(
    parameter logic [31:0] T0_BASE = 32'h0000_0000,
    parameter logic [31:0] T0_MASK = 32'hF000_0000,
    parameter logic [31:0] T1_BASE = 32'h1000_0000,
    parameter logic [31:0] T1_MASK = 32'hF000_0000,
    parameter logic [31:0] T2_BASE = 32'h2000_0000,
    parameter logic [31:0] T2_MASK = 32'hFFFF_F000,
    parameter int          TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m_req_valid,
    output logic        m_req_ready,
    input  logic [31:0] m_addr,
    input  logic        m_we,
    input  logic [3:0]  m_wstrb,
    input  logic [31:0] m_wdata,
    output logic        m_resp_valid,
    output logic [31:0] m_resp_rdata,
    output logic        m_resp_err,
    output logic [2:0]  s_req_valid,
    input  logic [2:0]  s_req_ready,
    output logic [31:0] s_addr,
    output logic        s_we,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic [2:0]  s_resp_valid,
    input  logic [95:0] s_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      s_addr_q, s_addr_d;
    logic             s_we_q, s_we_d;
    logic [3:0]       s_wstrb_q, s_wstrb_d;
    logic [31:0]      s_wdata_q, s_wdata_d;
    logic             m_resp_valid_q, m_resp_valid_d;
    logic             m_resp_err_q, m_resp_err_d;
    logic [31:0]      m_resp_rdata_q, m_resp_rdata_d;

    logic             hit0, hit1, hit2;
    logic [2:0]       sel_onehot;
    logic             tgt_req_ready;
    logic             tgt_resp_valid;
    logic [31:0]      tgt_rdata;

    assign hit0 = (m_addr & T0_MASK) == T0_BASE;
    assign hit1 = (m_addr & T1_MASK) == T1_BASE;
    assign hit2 = (m_addr & T2_MASK) == T2_BASE;

    // Selected-target views; sel_q == 3 never occurs but decodes to "no target".
    always_comb begin
        sel_onehot     = 3'b000;
        tgt_req_ready  = 1'b0;
        tgt_resp_valid = 1'b0;
        tgt_rdata      = 32'h0;
        case (sel_q)
            2'd0: begin
                sel_onehot     = 3'b001;
                tgt_req_ready  = s_req_ready[0];
                tgt_resp_valid = s_resp_valid[0];
                tgt_rdata      = s_rdata[31:0];
            end
            2'd1: begin
                sel_onehot     = 3'b010;
                tgt_req_ready  = s_req_ready[1];
                tgt_resp_valid = s_resp_valid[1];
                tgt_rdata      = s_rdata[63:32];
            end
            2'd2: begin
                sel_onehot     = 3'b100;
                tgt_req_ready  = s_req_ready[2];
                tgt_resp_valid = s_resp_valid[2];
                tgt_rdata      = s_rdata[95:64];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        s_addr_d       = s_addr_q;
        s_we_d         = s_we_q;
        s_wstrb_d      = s_wstrb_q;
        s_wdata_d      = s_wdata_q;
        m_resp_valid_d = 1'b0;
        m_resp_err_d   = m_resp_err_q;
        m_resp_rdata_d = m_resp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (m_req_valid) begin
                    s_addr_d  = m_addr;
                    s_we_d    = m_we;
                    s_wstrb_d = m_wstrb;
                    s_wdata_d = m_wdata;
                    cnt_d     = '0;
                    if (hit0) begin
                        sel_d   = 2'd0;
                        state_d = S_ISSUE;
                    end else if (hit1) begin
                        sel_d   = 2'd1;
                        state_d = S_ISSUE;
                    end else if (hit2) begin
                        sel_d   = 2'd2;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d        = S_IDLE;
                    m_resp_valid_d = 1'b1;
                    m_resp_err_d   = 1'b1;
                    m_resp_rdata_d = 32'h0;
                end else if (tgt_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response on the final counted cycle beats the timeout.
                if (tgt_resp_valid) begin
                    state_d        = S_IDLE;
                    m_resp_valid_d = 1'b1;
                    m_resp_err_d   = 1'b0;
                    m_resp_rdata_d = tgt_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = S_IDLE;
                    m_resp_valid_d = 1'b1;
                    m_resp_err_d   = 1'b1;
                    m_resp_rdata_d = 32'h0;
                end
            end
            default: begin
                state_d        = S_IDLE;
                m_resp_valid_d = 1'b1;
                m_resp_err_d   = 1'b1;
                m_resp_rdata_d = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            sel_q          <= 2'd0;
            cnt_q          <= '0;
            s_addr_q       <= 32'h0;
            s_we_q         <= 1'b0;
            s_wstrb_q      <= 4'h0;
            s_wdata_q      <= 32'h0;
            m_resp_valid_q <= 1'b0;
            m_resp_err_q   <= 1'b0;
            m_resp_rdata_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            cnt_q          <= cnt_d;
            s_addr_q       <= s_addr_d;
            s_we_q         <= s_we_d;
            s_wstrb_q      <= s_wstrb_d;
            s_wdata_q      <= s_wdata_d;
            m_resp_valid_q <= m_resp_valid_d;
            m_resp_err_q   <= m_resp_err_d;
            m_resp_rdata_q <= m_resp_rdata_d;
        end
    end

    assign m_req_ready  = (state_q == S_IDLE);
    assign s_req_valid  = (state_q == S_ISSUE) ? sel_onehot : 3'b000;
    assign s_addr       = s_addr_q;
    assign s_we         = s_we_q;
    assign s_wstrb      = s_wstrb_q;
    assign s_wdata      = s_wdata_q;
    assign m_resp_valid = m_resp_valid_q;
    assign m_resp_err   = m_resp_err_q;
    assign m_resp_rdata = m_resp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dbus_demux3.sv
// ============================================================================
// tb_dbus_demux3 : directed self-checking bench for dbus_demux3
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dbus_demux3;

    logic        clk;
    logic        rstn;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_addr;
    logic        m_we;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic        m_resp_valid;
    logic [31:0] m_resp_rdata;
    logic        m_resp_err;
    logic [2:0]  s_req_valid;
    logic [2:0]  s_req_ready;
    logic [31:0] s_addr;
    logic        s_we;
    logic [3:0]  s_wstrb;
    logic [31:0] s_wdata;
    logic [2:0]  s_resp_valid;
    logic [95:0] s_rdata;

    int checks = 0;
    int errors = 0;

    dbus_demux3 dut (
        .clk          (clk),
        .rstn         (rstn),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_addr       (m_addr),
        .m_we         (m_we),
        .m_wstrb      (m_wstrb),
        .m_wdata      (m_wdata),
        .m_resp_valid (m_resp_valid),
        .m_resp_rdata (m_resp_rdata),
        .m_resp_err   (m_resp_err),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_addr       (s_addr),
        .s_we         (s_we),
        .s_wstrb      (s_wstrb),
        .s_wdata      (s_wdata),
        .s_resp_valid (s_resp_valid),
        .s_rdata      (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resp_chk(input string tag, input logic [31:0] rdata, input logic err);
        check({tag, "_valid"}, {127'h0, m_resp_valid}, 128'h1);
        check({tag, "_rdata"}, {96'h0, m_resp_rdata}, {96'h0, rdata});
        check({tag, "_err"},   {127'h0, m_resp_err},   {127'h0, err});
    endtask

    initial begin
        rstn = 1'b0; m_req_valid = 1'b0; m_addr = 32'h0; m_we = 1'b0;
        m_wstrb = 4'h0; m_wdata = 32'h0; s_req_ready = 3'b000;
        s_resp_valid = 3'b000; s_rdata = 96'h0;

        // Reset values, before any clock edge
        #2;
        check("rst_ready",  {127'h0, m_req_ready}, 128'h1);
        check("rst_sreqv",  {125'h0, s_req_valid}, 128'h0);
        check("rst_resp",   {94'h0, m_resp_valid, m_resp_err, m_resp_rdata}, 128'h0);
        check("rst_fields", {59'h0, s_addr, s_we, s_wstrb, s_wdata}, 128'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Load from DMEM, minimum latency
        m_req_valid = 1'b1; m_addr = 32'h0000_0040; m_we = 1'b0; s_req_ready = 3'b001;
        check("t1_ready_c0", {127'h0, m_req_ready}, 128'h1);
        tick();
        m_req_valid = 1'b0;
        check("t1_sreqv_c1", {125'h0, s_req_valid}, 128'h1);
        check("t1_ready_c1", {127'h0, m_req_ready}, 128'h0);
        check("t1_saddr",    {96'h0, s_addr}, 128'h40);
        tick();
        check("t1_sreqv_c2", {125'h0, s_req_valid}, 128'h0);
        check("t1_rv_c2",    {127'h0, m_resp_valid}, 128'h0);
        s_resp_valid = 3'b001; s_rdata = {64'h0, 32'hDEAD_BEEF};
        tick();
        s_resp_valid = 3'b000;
        resp_chk("t1_c3", 32'hDEAD_BEEF, 1'b0);
        check("t1_ready_c3", {127'h0, m_req_ready}, 128'h1);
        tick();
        check("t1_rv_c4", {127'h0, m_resp_valid}, 128'h0);
        check("t1_hold",  {96'h0, m_resp_rdata}, 128'hDEAD_BEEF);

        // Store to MMIO with three cycles of backpressure
        m_req_valid = 1'b1; m_addr = 32'h1000_0004; m_we = 1'b1;
        m_wstrb = 4'b0011; m_wdata = 32'h0000_1234; s_req_ready = 3'b000;
        tick();
        m_req_valid = 1'b0; m_addr = 32'hFFFF_FFFF; m_we = 1'b0; m_wstrb = 4'h0; m_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("t2_sreqv",   {125'h0, s_req_valid}, 128'h2);
            check("t2_fields",  {59'h0, s_addr, s_we, s_wstrb, s_wdata},
                                {59'h0, 32'h1000_0004, 1'b1, 4'b0011, 32'h0000_1234});
            if (i == 3) s_req_ready = 3'b010;
            tick();
        end
        check("t2_sreqv_wait", {125'h0, s_req_valid}, 128'h0);
        s_resp_valid = 3'b010; s_rdata = {32'h0, 32'hCAFE_0001, 32'h0};
        tick();
        s_resp_valid = 3'b000; s_req_ready = 3'b000;
        resp_chk("t2", 32'hCAFE_0001, 1'b0);
        tick();

        // Timer decode
        m_req_valid = 1'b1; m_addr = 32'h2000_0F00; s_req_ready = 3'b100;
        tick();
        m_req_valid = 1'b0;
        check("t3_sreqv", {125'h0, s_req_valid}, 128'h4);
        tick();
        s_resp_valid = 3'b100; s_rdata = {32'h0000_0777, 64'h0};
        tick();
        s_resp_valid = 3'b000; s_req_ready = 3'b000;
        resp_chk("t3", 32'h0000_0777, 1'b0);
        tick();

        // Decode miss just past the timer window
        m_req_valid = 1'b1; m_addr = 32'h2000_1000;
        tick();
        m_req_valid = 1'b0;
        check("t3m_sreqv_c1", {125'h0, s_req_valid}, 128'h0);
        check("t3m_rv_c1",    {127'h0, m_resp_valid}, 128'h0);
        check("t3m_ready_c1", {127'h0, m_req_ready}, 128'h0);
        tick();
        resp_chk("t3m_c2", 32'h0, 1'b1);
        check("t3m_sreqv_c2", {125'h0, s_req_valid}, 128'h0);
        check("t3m_ready_c2", {127'h0, m_req_ready}, 128'h1);
        tick();
        check("t3m_rv_c3", {127'h0, m_resp_valid}, 128'h0);

        // Timeout: T1 accepts but never responds
        m_req_valid = 1'b1; m_addr = 32'h1000_0000; s_req_ready = 3'b010;
        tick();
        m_req_valid = 1'b0;
        check("t4_sreqv_c1", {125'h0, s_req_valid}, 128'h2);
        repeat (15) tick();
        check("t4_rv_c16",    {127'h0, m_resp_valid}, 128'h0);
        check("t4_sreqv_c16", {125'h0, s_req_valid}, 128'h0);
        tick();
        resp_chk("t4_c17", 32'h0, 1'b1);
        tick();
        check("t4_rv_c18", {127'h0, m_resp_valid}, 128'h0);

        // Response on the timeout cycle wins
        m_req_valid = 1'b1; m_addr = 32'h1000_0000;
        tick();
        m_req_valid = 1'b0;
        repeat (15) tick();
        check("t4b_rv_c16", {127'h0, m_resp_valid}, 128'h0);
        s_resp_valid = 3'b010; s_rdata = {32'h0, 32'h5555_AAAA, 32'h0};
        tick();
        s_resp_valid = 3'b000; s_req_ready = 3'b000;
        resp_chk("t4b_c17", 32'h5555_AAAA, 1'b0);
        tick();

        // Spurious responses in IDLE, in ISSUE, and from unselected targets
        s_resp_valid = 3'b111; s_rdata = {3{32'h9999_9999}};
        tick();
        s_resp_valid = 3'b000;
        check("t5_idle_rv", {127'h0, m_resp_valid}, 128'h0);
        m_req_valid = 1'b1; m_addr = 32'h1000_0008;
        tick();
        m_req_valid = 1'b0; s_resp_valid = 3'b111;
        tick();
        check("t5_sreqv_issue", {125'h0, s_req_valid}, 128'h2);
        check("t5_issue_rv",    {127'h0, m_resp_valid}, 128'h0);
        s_resp_valid = 3'b000; s_req_ready = 3'b010;
        tick();
        check("t5_rv_c3", {127'h0, m_resp_valid}, 128'h0);
        s_resp_valid = 3'b101; s_rdata = {32'hAAAA_0002, 32'h1111_2222, 32'hAAAA_0000};
        tick();
        check("t5_other_rv", {127'h0, m_resp_valid}, 128'h0);
        s_resp_valid = 3'b010;
        tick();
        s_resp_valid = 3'b000; s_req_ready = 3'b000;
        resp_chk("t5", 32'h1111_2222, 1'b0);
        tick();

        // Reset during WAIT abandons the transaction
        m_req_valid = 1'b1; m_addr = 32'h0000_0100; m_we = 1'b1; m_wstrb = 4'hF;
        m_wdata = 32'h1357_9BDF; s_req_ready = 3'b001;
        tick();
        m_req_valid = 1'b0;
        tick();
        check("t6_inwait_ready", {127'h0, m_req_ready}, 128'h0);
        #2 rstn = 1'b0;
        s_resp_valid = 3'b001; s_rdata = {64'h0, 32'hBAD0_BAD0};
        #1;
        check("t6_rst_ready",  {127'h0, m_req_ready}, 128'h1);
        check("t6_rst_resp",   {94'h0, m_resp_valid, m_resp_err, m_resp_rdata}, 128'h0);
        check("t6_rst_fields", {59'h0, s_addr, s_we, s_wstrb, s_wdata}, 128'h0);
        @(posedge clk); #1;
        rstn = 1'b1; s_resp_valid = 3'b000;
        check("t6_post_rv", {127'h0, m_resp_valid}, 128'h0);
        tick();
        check("t6_post_rv2", {127'h0, m_resp_valid}, 128'h0);
        m_req_valid = 1'b1; m_addr = 32'h0000_0200; m_we = 1'b0;
        tick();
        m_req_valid = 1'b0;
        check("t6_sreqv", {125'h0, s_req_valid}, 128'h1);
        tick();
        s_resp_valid = 3'b001; s_rdata = {64'h0, 32'h600D_F00D};
        tick();
        s_resp_valid = 3'b000;
        resp_chk("t6", 32'h600D_F00D, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
